clock_div: RTL and testbench

Synchronous fixed-ratio clock divider. Produces a 50 %-duty square wave `out` with a period of exactly 2·DIVIDER input clock cycles. It derives slow enables and visible strobes, such as LED blink or 1 Hz ticks, from the board oscillator. `out` is a registered fabric signal, not a clock-tree net; downstream logic samples it as data in the `clk` domain.

---
 rtl/clock_div.sv | 45 ++++
 tb/tb_clock_div.sv | 121 ++++++++++++
 2 files changed

// File: rtl/clock_div.sv
// rtl/clock_div.sv - fixed-ratio divider producing a 50% duty square wave of period 2*DIVIDER clk cycles
// Optional build macro CLOCK_DIV_PARAM_CHECK_EN adds parameter and runtime sanity checks.
module clock_div #(
    parameter int DIV_WIDTH = 24,
    parameter int DIVIDER   = 6000000
) (
    input  logic clk,
    input  logic rst,
    output logic out
);

    localparam logic [DIV_WIDTH-1:0] TERMINAL = DIV_WIDTH'(DIVIDER - 1);

    // Declaration initialisers make simulation match the post-reset state before the first reset.
    logic [DIV_WIDTH-1:0] count = '0;
    logic                 out_q = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            out_q <= 1'b0;
        end else if (count == TERMINAL) begin
            count <= '0;
            out_q <= ~out_q;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign out = out_q;

`ifdef CLOCK_DIV_PARAM_CHECK_EN
    if (DIVIDER < 1 || (longint'(DIVIDER) - 1) >= (longint'(1) << DIV_WIDTH)) begin : g_bad_divider
        $error("clock_div: DIVIDER=%0d illegal for DIV_WIDTH=%0d", DIVIDER, DIV_WIDTH);
    end

    a_count_range: assert property (@(posedge clk) count <= TERMINAL);

    // A toggle seen now must come from a terminal count on the edge that produced it.
    a_toggle_cause: assert property (@(posedge clk)
        (!$past(rst) && (out_q != $past(out_q))) |-> ($past(count) == TERMINAL));
`else
`endif

endmodule

// File: tb/tb_clock_div.sv
// tb/tb_clock_div.sv - self-checking bench for clock_div at DIVIDER 9, 1 and 16
module tb_clock_div;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic o9, o1, o16;

    always #5 clk = ~clk;

    clock_div #(.DIV_WIDTH(4), .DIVIDER(9))  u9  (.clk(clk), .rst(rst), .out(o9));
    clock_div #(.DIV_WIDTH(1), .DIVIDER(1))  u1  (.clk(clk), .rst(rst), .out(o1));
    clock_div #(.DIV_WIDTH(4), .DIVIDER(16)) u16 (.clk(clk), .rst(rst), .out(o16));

    typedef struct {
        logic rst;
        int   o9;
        int   c9;
        int   o1;
        int   o16;
    } vec_t;

    vec_t   tbl[20];
    int     vectors     = 0;
    int     miscompares = 0;
    longint n           = 0;   // edges with rst=0 since the last reset edge

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at t=%0t n=%0d", name, act, exp, $time, n);
        end
    endtask

    task automatic edge_step(input logic r);
        rst = r;
        @(posedge clk);
        #1;
        if (r) n = 0;
        else   n++;
    endtask

    // Reference: after n counting edges, count = n mod D and out = floor(n/D) mod 2.
    task automatic check_model(input string tag);
        chk({tag, " out9"},  int'(o9),        int'((n / 9) % 2));
        chk({tag, " cnt9"},  int'(u9.count),  int'(n % 9));
        chk({tag, " out1"},  int'(o1),        int'(n % 2));
        chk({tag, " cnt1"},  int'(u1.count),  0);
        chk({tag, " out16"}, int'(o16),       int'((n / 16) % 2));
        chk({tag, " cnt16"}, int'(u16.count), int'(n % 16));
    endtask

    initial begin
        tbl[0]  = '{1'b1, 0, 0, 0, 0};
        tbl[1]  = '{1'b0, 0, 1, 1, 0};
        tbl[2]  = '{1'b0, 0, 2, 0, 0};
        tbl[3]  = '{1'b0, 0, 3, 1, 0};
        tbl[4]  = '{1'b0, 0, 4, 0, 0};
        tbl[5]  = '{1'b0, 0, 5, 1, 0};
        tbl[6]  = '{1'b0, 0, 6, 0, 0};
        tbl[7]  = '{1'b0, 0, 7, 1, 0};
        tbl[8]  = '{1'b0, 0, 8, 0, 0};
        tbl[9]  = '{1'b0, 1, 0, 1, 0};
        tbl[10] = '{1'b0, 1, 1, 0, 0};
        tbl[11] = '{1'b0, 1, 2, 1, 0};
        tbl[12] = '{1'b0, 1, 3, 0, 0};
        tbl[13] = '{1'b0, 1, 4, 1, 0};
        tbl[14] = '{1'b0, 1, 5, 0, 0};
        tbl[15] = '{1'b0, 1, 6, 1, 0};
        tbl[16] = '{1'b0, 1, 7, 0, 1};
        tbl[17] = '{1'b0, 1, 8, 1, 1};
        tbl[18] = '{1'b0, 0, 0, 0, 1};
        tbl[19] = '{1'b0, 0, 1, 1, 1};

        for (int i = 0; i < 20; i++) begin
            edge_step(tbl[i].rst);
            chk($sformatf("tbl%0d out9", i),  int'(o9),       tbl[i].o9);
            chk($sformatf("tbl%0d cnt9", i),  int'(u9.count), tbl[i].c9);
            chk($sformatf("tbl%0d out1", i),  int'(o1),       tbl[i].o1);
            chk($sformatf("tbl%0d out16", i), int'(o16),      tbl[i].o16);
        end

        // Full 32-cycle period of the maximum-width divider with no overflow.
        edge_step(1'b1);
        for (int k = 1; k <= 40; k++) begin
            edge_step(1'b0);
            check_model("max");
        end

        // Mid-period reset: out=1 and count=5 on the 9-divider, hold reset for 3 edges.
        edge_step(1'b1);
        for (int k = 0; k < 14; k++) edge_step(1'b0);
        chk("mid pre out9", int'(o9), 1);
        chk("mid pre cnt9", int'(u9.count), 5);
        for (int k = 0; k < 3; k++) begin
            edge_step(1'b1);
            chk("mid rst out9", int'(o9), 0);
            chk("mid rst cnt9", int'(u9.count), 0);
        end
        for (int k = 1; k <= 9; k++) begin
            edge_step(1'b0);
            chk("mid rel out9", int'(o9), (k == 9) ? 1 : 0);
        end

        // A narrow rst pulse between edges must be ignored.
        #3 rst = 1'b1;
        #1 rst = 1'b0;
        edge_step(1'b0);
        check_model("glitch");

        // Randomised reset pattern against the arithmetic reference.
        for (int k = 0; k < 3000; k++) begin
            edge_step($urandom_range(0, 99) < 3);
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
